// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode constants, encodings and the ID/EX payload.
package riscv_pkg;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} immSrc_t;
    typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4} resultSrc_t;
    typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluOp_t;
    typedef struct packed {
        logic        regWrite;
        logic        memWrite;
        logic        jump;
        logic        branch;
        logic        aluSrc;
        resultSrc_t  resultSrc;
        logic [2:0]  aluControl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] immExt;
        logic [31:0] pc;
        logic [31:0] pcPlus4;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } idEx_t;
endpackage

// File: rtl/decode_cycle_if.sv
// decode_cycle_if: IF/ID inputs, writeback port, hazard taps and ID/EX outputs of the decode stage.
interface decode_cycle_if;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    logic        FlushE;
    logic [4:0]  Rs1D, Rs2D;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  RdE, Rs1E, Rs2E;
    modport master (
        output InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
        input  Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
               ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, Rs1E, Rs2E
    );
    modport slave (
        input  InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
        output Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
               ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, Rs1E, Rs2E
    );
endinterface

// File: rtl/register_file.sv
// register_file: 31 writable registers plus hardwired x0, with writeback-to-read bypass.
module register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [4:0]  A3,
    input  logic        WE3,
    input  logic [31:0] WD3,
    output logic [31:0] RD1,
    output logic [31:0] RD2
);
    logic [31:0] regs [1:31];
    logic        wrEn;
    assign wrEn = WE3 && A3 != 5'd0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            for (int i = 1; i < 32; i++) regs[i] <= '0;
        else if (wrEn)
            regs[A3] <= WD3;
    end
    // Bypass lets an instruction in decode see the value being written back this cycle
    assign RD1 = A1 == 5'd0 ? '0 : (wrEn && A3 == A1) ? WD3 : regs[A1];
    assign RD2 = A2 == 5'd0 ? '0 : (wrEn && A3 == A2) ? WD3 : regs[A2];
endmodule

// File: rtl/decode_cycle.sv
// decode_cycle: RV32I decode stage -- control/ALU decode, register read, immediate
// extension and the ID/EX pipeline register.
module decode_cycle
    import riscv_pkg::*;
(
    input logic clk,
    input logic rst,
    decode_cycle_if.slave bus
);
    logic [31:0] instr, rd1, rd2, immExt;
    logic [6:0]  op;
    logic [2:0]  funct3, aluControl;
    logic        regWrite, memWrite, branch, jump, aluSrc;
    resultSrc_t  resultSrc;
    immSrc_t     immSrc;
    aluOp_t      aluOp;
    idEx_t       d, q;
    assign instr  = bus.InstrD;
    assign op     = instr[6:0];
    assign funct3 = instr[14:12];
    assign bus.Rs1D = instr[19:15];
    assign bus.Rs2D = instr[24:20];
    register_file rf (
        .clk(clk), .rst(rst), .A1(instr[19:15]), .A2(instr[24:20]), .A3(bus.RDW),
        .WE3(bus.RegWriteW), .WD3(bus.ResultW), .RD1(rd1), .RD2(rd2)
    );
    // Unknown opcodes keep every default, turning the slot into a bubble
    always_comb begin
        regWrite  = 1'b0;
        memWrite  = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        aluSrc    = 1'b0;
        resultSrc = RES_ALU;
        immSrc    = IMM_I;
        aluOp     = ALUOP_ADD;
        case (op)
            OP_LW:  begin regWrite = 1'b1; aluSrc = 1'b1; resultSrc = RES_MEM; end
            OP_SW:  begin memWrite = 1'b1; aluSrc = 1'b1; immSrc = IMM_S; end
            OP_R:   begin regWrite = 1'b1; aluOp = ALUOP_FUNCT; end
            OP_I:   begin regWrite = 1'b1; aluSrc = 1'b1; aluOp = ALUOP_FUNCT; end
            OP_BEQ: begin branch = 1'b1; immSrc = IMM_B; aluOp = ALUOP_SUB; end
            OP_JAL: begin regWrite = 1'b1; jump = 1'b1; resultSrc = RES_PC4; immSrc = IMM_J; end
            default: ;
        endcase
    end
    assign aluControl = aluOp == ALUOP_SUB   ? ALU_SUB :
                        aluOp != ALUOP_FUNCT ? ALU_ADD :
                        funct3 == 3'b010     ? ALU_SLT :
                        funct3 == 3'b110     ? ALU_OR  :
                        funct3 == 3'b111     ? ALU_AND :
                        (funct3 == 3'b000 && op == OP_R && instr[30]) ? ALU_SUB : ALU_ADD;
    assign immExt = immSrc == IMM_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
                    immSrc == IMM_B ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
                    immSrc == IMM_J ? {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
                                      {{20{instr[31]}}, instr[31:20]};
    assign d = '{regWrite: regWrite, memWrite: memWrite, jump: jump, branch: branch,
                 aluSrc: aluSrc, resultSrc: resultSrc, aluControl: aluControl,
                 rd1: rd1, rd2: rd2, immExt: immExt, pc: bus.PCD, pcPlus4: bus.PCPlus4D,
                 rd: instr[11:7], rs1: instr[19:15], rs2: instr[24:20]};
    // Flush zeroes the indices too so forwarding never matches a bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            q <= '0;
        else if (bus.FlushE) q <= '0;
        else                 q <= d;
    end
    assign bus.RegWriteE   = q.regWrite;
    assign bus.MemWriteE   = q.memWrite;
    assign bus.JumpE       = q.jump;
    assign bus.BranchE     = q.branch;
    assign bus.ALUSrcE     = q.aluSrc;
    assign bus.ResultSrcE  = q.resultSrc;
    assign bus.ALUControlE = q.aluControl;
    assign bus.RD1E        = q.rd1;
    assign bus.RD2E        = q.rd2;
    assign bus.ImmExtE     = q.immExt;
    assign bus.PCE         = q.pc;
    assign bus.PCPlus4E    = q.pcPlus4;
    assign bus.RdE         = q.rd;
    assign bus.Rs1E        = q.rs1;
    assign bus.Rs2E        = q.rs2;
endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: randomized and directed checks of decode_cycle against a behavioural model.
module tb_decode_cycle;
    logic clk = 1'b0;
    logic rst = 1'b1;
    decode_cycle_if bus();
    decode_cycle dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [31:0] mregs [32];
    logic [31:0] eCtrl, eRd1, eRd2, eImm, ePc, ePc4, eIdx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] readReg(input logic [4:0] a);
        if (a == 0) return 0;
        if (bus.RegWriteW && bus.RDW == a) return bus.ResultW;
        return mregs[a];
    endfunction

    task automatic predict();
        logic [31:0] i;
        logic [6:0] op;
        logic [2:0] f3;
        logic rw, mw, jp, br, as;
        logic [1:0] rs;
        logic [2:0] alu;
        i = bus.InstrD; op = i[6:0]; f3 = i[14:12];
        rw = op inside {7'b0000011, 7'b0110011, 7'b0010011, 7'b1101111};
        mw = op == 7'b0100011;
        br = op == 7'b1100011;
        jp = op == 7'b1101111;
        as = op inside {7'b0000011, 7'b0100011, 7'b0010011};
        rs = op == 7'b0000011 ? 2'b01 : jp ? 2'b10 : 2'b00;
        alu = 3'b000;
        if (br) alu = 3'b001;
        else if (op == 7'b0110011 || op == 7'b0010011) begin
            if (f3 == 3'b010) alu = 3'b101;
            else if (f3 == 3'b110) alu = 3'b011;
            else if (f3 == 3'b111) alu = 3'b010;
            else if (f3 == 3'b000 && op == 7'b0110011 && i[30]) alu = 3'b001;
        end
        if (mw)      eImm = 32'($signed({i[31:25], i[11:7]}));
        else if (br) eImm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        else if (jp) eImm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        else         eImm = 32'($signed(i[31:20]));
        eCtrl = {22'd0, rw, mw, jp, br, as, rs, alu};
        eRd1 = readReg(i[19:15]);
        eRd2 = readReg(i[24:20]);
        ePc = bus.PCD;
        ePc4 = bus.PCPlus4D;
        eIdx = {17'd0, i[11:7], i[19:15], i[24:20]};
        if (bus.FlushE) {eCtrl, eRd1, eRd2, eImm, ePc, ePc4, eIdx} = '0;
    endtask

    task automatic checkOutputs(input string tag);
        check({tag, ".ctrl"}, {22'd0, bus.RegWriteE, bus.MemWriteE, bus.JumpE, bus.BranchE,
              bus.ALUSrcE, bus.ResultSrcE, bus.ALUControlE}, eCtrl);
        check({tag, ".rd1"}, bus.RD1E, eRd1);
        check({tag, ".rd2"}, bus.RD2E, eRd2);
        check({tag, ".imm"}, bus.ImmExtE, eImm);
        check({tag, ".pc"}, bus.PCE, ePc);
        check({tag, ".pc4"}, bus.PCPlus4E, ePc4);
        check({tag, ".idx"}, {17'd0, bus.RdE, bus.Rs1E, bus.Rs2E}, eIdx);
    endtask

    task automatic drive(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                         input logic we, input logic [4:0] rdw, input logic [31:0] wd,
                         input logic flush);
        bus.InstrD = instr; bus.PCD = pc; bus.PCPlus4D = pc + 4;
        bus.RegWriteW = we; bus.RDW = rdw; bus.ResultW = wd; bus.FlushE = flush;
        #1;
        check({tag, ".rs1d"}, {27'd0, bus.Rs1D}, {27'd0, instr[19:15]});
        check({tag, ".rs2d"}, {27'd0, bus.Rs2D}, {27'd0, instr[24:20]});
        predict();
        @(posedge clk);
        if (we && rdw != 0) mregs[rdw] = wd;
        #1;
        checkOutputs(tag);
    endtask

    task automatic randomRun(input int n);
        logic [6:0] ops [7];
        logic [31:0] instr;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b0};
        for (int k = 0; k < n; k++) begin
            instr = $urandom;
            if ($urandom_range(7) != 0) instr[6:0] = ops[$urandom_range(6)];
            drive("rand", instr, $urandom, 1'($urandom), 5'($urandom), $urandom,
                  $urandom_range(7) == 0);
        end
    endtask

    task automatic checkAllZero(input string tag);
        {eCtrl, eRd1, eRd2, eImm, ePc, ePc4, eIdx} = '0;
        checkOutputs(tag);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) mregs[r] = 0;
        bus.InstrD = 0; bus.PCD = 0; bus.PCPlus4D = 0;
        bus.RegWriteW = 0; bus.RDW = 0; bus.ResultW = 0; bus.FlushE = 0;
        #1 rst = 1'b0;
        #1 checkAllZero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        drive("bubble", 32'h0, 32'h0, 0, 0, 0, 0);
        drive("wr_byp", 32'h002081B3, 32'h10, 1, 1, 32'd5, 0);
        check("wr_byp.rd1_5", bus.RD1E, 32'd5);
        check("wr_byp.rdE", {27'd0, bus.RdE}, 32'd3);
        drive("rd_arr", 32'h002081B3, 32'h14, 0, 0, 0, 0);
        check("rd_arr.rd1_5", bus.RD1E, 32'd5);
        drive("x0_wr", 32'h0, 32'h18, 1, 0, 32'hDEAD, 0);
        drive("x0_rd", 32'h00000033, 32'h1C, 0, 0, 0, 0);
        check("x0_rd.rd1", bus.RD1E, 32'd0);
        drive("lw", 32'hFFC12283, 32'h20, 0, 0, 0, 0);
        check("lw.imm", bus.ImmExtE, 32'hFFFFFFFC);
        check("lw.rsrc", {30'd0, bus.ResultSrcE}, 32'd1);
        drive("sw", 32'h0020A423, 32'h24, 0, 0, 0, 0);
        check("sw.imm", bus.ImmExtE, 32'd8);
        check("sw.mw", {31'd0, bus.MemWriteE}, 32'd1);
        drive("beq", 32'hFE208EE3, 32'h28, 0, 0, 0, 0);
        check("beq.imm", bus.ImmExtE, 32'hFFFFFFFC);
        check("beq.alu", {29'd0, bus.ALUControlE}, 32'd1);
        drive("jal", 32'h008000EF, 32'h2C, 0, 0, 0, 0);
        check("jal.imm", bus.ImmExtE, 32'd8);
        check("jal.rsrc", {30'd0, bus.ResultSrcE}, 32'd2);
        drive("flush", 32'h002081B3, 32'h30, 1, 7, 32'd9, 1);
        check("flush.idx", {17'd0, bus.RdE, bus.Rs1E, bus.Rs2E}, 32'd0);
        drive("x7_rd", 32'h00038433, 32'h34, 0, 0, 0, 0);
        check("x7_rd.rd1", bus.RD1E, 32'd9);
        drive("pass", 32'h0, 32'h100, 0, 0, 0, 0);
        check("pass.pc", bus.PCE, 32'h100);
        check("pass.pc4", bus.PCPlus4E, 32'h104);
        randomRun(300);
        bus.RegWriteW = 0;
        rst = 1'b0;
        #1 checkAllZero("mid_rst");
        for (int r = 0; r < 32; r++) mregs[r] = 0;
        @(posedge clk);
        #1 checkAllZero("mid_rst_hold");
        rst = 1'b1;
        drive("post_rst", 32'h002081B3, 32'h40, 0, 0, 0, 0);
        check("post_rst.rd1", bus.RD1E, 32'd0);
        randomRun(300);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decode_cycle.md
# decode_cycle

Decode stage of the five-stage RV32I pipeline, directly downstream of the fetch stage. It consumes the IF/ID outputs (`InstrD`, `PCD`, `PCPlus4D`) and performs four jobs:
- generates control signals from the opcode/funct fields;
- reads two operands from a 32×32 register file, which is written back by the writeback stage;
- sign-extends the immediate;
- registers everything into the ID/EX pipeline register for the execute stage.

It also exports the source register indices to the hazard unit.

## Interface
- No parameters; widths fixed (XLEN 32, 32 registers).
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `InstrD`, `PCD`, `PCPlus4D` in 32 each: from the IF/ID register.
- `RegWriteW` in 1: writeback enable.
- `RDW` in 5: writeback destination.
- `ResultW` in 32: writeback data.
- `FlushE` in 1: synchronous bubble insert into ID/EX.
- `Rs1D`, `Rs2D` out 5: `InstrD[19:15]`, `InstrD[24:20]`, combinational, to the hazard unit.
- `RegWriteE`, `MemWriteE`, `JumpE`, `BranchE`, `ALUSrcE` out 1: registered controls.
- `ResultSrcE` out 2: 00 ALU, 01 memory, 10 PC+4.
- `ALUControlE` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `RD1E`, `RD2E`, `ImmExtE`, `PCE`, `PCPlus4E` out 32: registered data.
- `RdE`, `Rs1E`, `Rs2E` out 5: registered register indices.

## Operation
- **Supported opcodes:**
  - lw 0000011
  - sw 0100011
  - R-type 0110011
  - I-ALU 0010011
  - beq 1100011
  - jal 1101111
- **Control decode:**
  - RegWrite = lw | R | I-ALU | jal.
  - MemWrite = sw.
  - Branch = beq.
  - Jump = jal.
  - ALUSrc = lw | sw | I-ALU.
  - ResultSrc = 01 for lw, 10 for jal, else 00.
- **Any other opcode (including 0x00000000 from FlushD)** drives every control output to 0 and ImmSrc to 00, so the instruction is a bubble.
- **ALU decode (ALUOp):**
  - ALUOp: lw/sw 00 → add; beq 01 → sub; R/I-ALU 10 → funct3-based.
  - funct3 000: add, except sub when R-type and funct7[5]=1 (`InstrD[30]`); I-type addi is always add.
  - funct3 010 → slt; 110 → or; 111 → and.
  - Any other funct3 → add.
- **Immediate (ImmSrc), sign bit always `InstrD[31]`:**
  - 00 I: `{20×s, InstrD[31:20]}`.
  - 01 S: `{20×s, InstrD[31:25], InstrD[11:7]}`.
  - 10 B: `{19×s, s, InstrD[7], InstrD[30:25], InstrD[11:8], 0}`.
  - 11 J: `{11×s, s, InstrD[19:12], InstrD[20], InstrD[30:21], 0}`.
- **Register file:**
  - x0 reads 0 always; writes to x0 are ignored.
  - Write happens on the rising edge when `RegWriteW`=1 and `RDW`≠0.
  - Read is combinational with write-through bypass: if `RegWriteW` && `RDW`≠0 && `RDW`==A, read data = `ResultW`. This resolves the WB→ID same-cycle hazard.
  - Reset clears all 31 registers to 0 asynchronously.
- **ID/EX register, priority rst > FlushE > capture:**
  - rst=0: every E output is 0, immediately and asynchronously.
  - FlushE=1: all E outputs ← 0 at the next edge. This includes `RdE`, `Rs1E` and `Rs2E`, so the forwarding unit never matches a bubble.
  - Otherwise capture every cycle. There is no StallE; a load-use stall is realised by FlushE with StallD.

## Timing
- Decode logic and register-file read are combinational from `InstrD`.
- Result is visible on E outputs exactly 1 cycle after `InstrD` presents.
- A writeback in cycle N:
  - is visible to a decode read in cycle N via the bypass;
  - is in the array from edge N+1.
- FlushE and a register write in the same cycle are independent: the write still commits.
- Reset deasserting mid-stream: the first capture occurs on the first rising edge with rst=1.
- Rs1D/Rs2D are raw fields even for opcodes without those sources; the hazard unit qualifies them.

## Structure
- **Shared package `riscv_pkg`:**
  - opcode constants;
  - ALUControl encodings;
  - ImmSrc encodings;
  - ResultSrc encodings.
- **Sub-modules:**
  - `register_file` (clk, rst, A1, A2, A3, WE3, WD3, RD1, RD2): holds storage and bypass.
  - Control decode, ALU decode and immediate extend are combinational blocks inside `decode_cycle`.

## Test plan
- **Reset:** rst=0 mid-run → all E outputs 0 immediately. After release, `0x00000000` decodes as a bubble: RegWriteE=0, MemWriteE=0.
- **Write then read:**
  - RegWriteW=1, RDW=1, ResultW=5 with `InstrD=0x002081B3` (add x3,x1,x2) → RD1E=5, ALUControlE=000, RdE=3.
  - The next cycle, without bypass, still reads 5.
- **x0 protection:** write RDW=0, ResultW=0xDEAD → a subsequent read of x0 gives RD1E=0.
- **Immediates:**
  - `0xFFC12283` (lw x5,-4(x2)) → ImmExtE=0xFFFFFFFC, ResultSrcE=01, ALUSrcE=1.
  - `0x0020A423` (sw) → ImmExtE=8, MemWriteE=1, RegWriteE=0.
  - `0xFE208EE3` (beq) → ImmExtE=0xFFFFFFFC, BranchE=1, ALUControlE=001.
  - `0x008000EF` (jal x1,8) → ImmExtE=8, JumpE=1, ResultSrcE=10, RdE=1.
- **Flush:** FlushE=1 with a valid add → next edge all E outputs 0, including RdE/Rs1E/Rs2E. A simultaneous RegWriteW of x7=9 is still committed; a later read of x7 returns 9.
- **Pass-through:** PCD=0x100, PCPlus4D=0x104 → PCE=0x100, PCPlus4E=0x104 one cycle later.
